ave_capture: RTL and testbench

- Downstream stage of the 8-sample moving averager; consumes its `ave8` output.
- The averager refreshes `ave8` once per fixed 10-cycle frame and has no valid strobe. This block regenerates that strobe from a phase counter.
- Each frame-aligned average is captured into a small FIFO and presented on a valid/ready stream for the next consumer.
- Reports overflow and fill level.

---
 rtl/ave_capture.sv | 132 +++++++++++++
 tb/tb_ave_capture.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ave_capture.sv
// ave_capture: rebuilds the frame strobe of the 8-sample moving averager from
// a phase counter, captures each frame-aligned average into a small FIFO and
// presents it on a valid/ready stream. Reports sticky overflow and fill level.
//
// Optional feature macro: AVE_CAPTURE_MINMAX_EN
//   Adds min8/max8 running statistics over successfully pushed samples,
//   cleared by clr_stats. Without the macro those ports and logic are absent.

module ave_capture #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 10,
  parameter int OFFSET = 10,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] ave8,
  input  logic             en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef AVE_CAPTURE_MINMAX_EN
  ,
  output logic [WIDTH-1:0] min8,
  output logic [WIDTH-1:0] max8,
  input  logic             clr_stats
`endif
);

  localparam int MAXV = (PERIOD > OFFSET) ? PERIOD : OFFSET;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0] OFFSET_LAST = CW'(OFFSET - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);
  localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   PTR_ONE     = (AW + 1)'(1);

  typedef enum logic {
    WARM_UP = 1'b0,
    RUN     = 1'b1
  } phase_t;

  phase_t          state;
  logic [CW-1:0]   cnt;
  logic            strobe;

  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic            push;
  logic            pop;
  logic            full;
  logic            wr_ok;
  logic            ovf_set;

  // Strobe marks the cycle in which the averager's output has just refreshed;
  // the first frame waits OFFSET edges, every later one PERIOD edges.
  assign strobe = (state == WARM_UP) ? (cnt == OFFSET_LAST) : (cnt == PERIOD_LAST);

  // Phase counter: warm-up until the first strobe, then free-running frames.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state <= WARM_UP;
      cnt   <= '0;
    end else if (strobe) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  // FIFO status: extra pointer bit distinguishes full from empty.
  assign count     = wptr - rptr;
  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign push      = strobe & en;
  assign pop       = out_valid & out_ready;
  assign wr_ok     = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign out_data  = out_valid ? mem[rptr[AW-1:0]] : '0;

  // Read/write pointers advance on accepted pushes and pops.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
    end
  end

  // Sample storage.
  // NOTE: the storage array has no reset; stale entries are never visible
  // because out_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= ave8;
  end

  // Sticky overflow; a drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs)          overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef AVE_CAPTURE_MINMAX_EN
  // Running min/max over pushed samples; a clear coinciding with a push
  // restarts the statistics from that sample.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      min8 <= '1;
      max8 <= '0;
    end else if (clr_stats) begin
      min8 <= wr_ok ? ave8 : '1;
      max8 <= wr_ok ? ave8 : '0;
    end else if (wr_ok) begin
      if (ave8 < min8) min8 <= ave8;
      if (ave8 > max8) max8 <= ave8;
    end
  end
`endif

endmodule

// File: tb/tb_ave_capture.sv
// tb_ave_capture: randomized and directed stimulus for ave_capture, checked
// every cycle against a queue-based reference model driven by an edge count
// since reset release.

module tb_ave_capture;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 10;
  localparam int OFFSET = 10;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic             clk;
  logic             rs;
  logic [WIDTH-1:0] ave8;
  logic             en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      count;
  logic             overflow;
  logic             clr_ovf;
`ifdef AVE_CAPTURE_MINMAX_EN
  logic [WIDTH-1:0] min8;
  logic [WIDTH-1:0] max8;
  logic             clr_stats;
`endif

  ave_capture #(
    .WIDTH (WIDTH),
    .PERIOD(PERIOD),
    .OFFSET(OFFSET),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rs       (rs),
    .ave8     (ave8),
    .en       (en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
`ifdef AVE_CAPTURE_MINMAX_EN
    ,
    .min8     (min8),
    .max8     (max8),
    .clr_stats(clr_stats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec;
  int n_err;

  // Reference model state.
  int q[$];
  bit m_ovf;
  int e;
  int m_min;
  int m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Edge k after reset release ends a strobe cycle.
  function automatic bit strobe_at(input int k);
    return (k == OFFSET) || (k > OFFSET && ((k - OFFSET) % PERIOD) == 0);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    e     = 0;
    m_min = 255;
    m_max = 0;
  endtask

  task automatic model_edge();
    bit stb, push, pop, full, wr, oset;
    e++;
    stb  = strobe_at(e);
    push = stb && en;
    pop  = (q.size() != 0) && out_ready;
    full = (q.size() == DEPTH);
    wr   = push && (!full || pop);
    oset = push && full && !pop;
    if (pop) void'(q.pop_front());
    if (wr) q.push_back(int'(ave8));
    if (oset) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
`ifdef AVE_CAPTURE_MINMAX_EN
    if (clr_stats) begin
      m_min = 255;
      m_max = 0;
    end
    if (wr) begin
      if (int'(ave8) < m_min) m_min = int'(ave8);
      if (int'(ave8) > m_max) m_max = int'(ave8);
    end
`endif
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".valid"}, out_valid, q.size() != 0);
    check({ph, ".count"}, count, q.size());
    check({ph, ".data"},  out_data, (q.size() != 0) ? q[0] : 0);
    check({ph, ".ovf"},   overflow, m_ovf);
`ifdef AVE_CAPTURE_MINMAX_EN
    check({ph, ".min8"},  min8, m_min);
    check({ph, ".max8"},  max8, m_max);
`endif
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle(input string ph);
    @(posedge clk);
    if (rs) model_edge();
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic run_to_strobe(input string ph);
    int g;
    bit hit;
    g   = 0;
    hit = 1'b0;
    while (!hit && g < PERIOD + OFFSET) begin
      hit = strobe_at(e + 1);
      cycle(ph);
      g++;
    end
    check({ph, ".strobe_seen"}, hit, 1);
  endtask

  task automatic run_to_pre_strobe(input string ph);
    int g;
    g = 0;
    while (!strobe_at(e + 1) && g < PERIOD + OFFSET) begin
      cycle(ph);
      g++;
    end
    check({ph, ".pre_strobe"}, strobe_at(e + 1), 1);
  endtask

  initial begin
    int pulses;
    int got[$];
    int exp_order[4];
    int g;

    n_vec     = 0;
    n_err     = 0;
    rs        = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    ave8      = '0;
`ifdef AVE_CAPTURE_MINMAX_EN
    clr_stats = 1'b0;
`endif
    model_reset();
    #1;
    compare_all("reset");
    repeat (2) @(negedge clk);
    rs = 1'b1;

    // Constant average, always ready: single-cycle valid pulses per frame.
    en        = 1'b1;
    out_ready = 1'b1;
    ave8      = 8'h2A;
    pulses    = 0;
    repeat (35) begin
      cycle("p1");
      if (out_valid === 1'b1) pulses++;
    end
    check("p1.pulses", pulses, 3);

    // Consumer stalled: fill with 1..4, fifth capture overflows.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ave8 = WIDTH'(k);
      run_to_strobe("p2");
    end
    check("p2.count_full", count, DEPTH);
    check("p2.head", out_data, 1);
    ave8 = 8'd5;
    run_to_strobe("p2");
    check("p2.ovf_set", overflow, 1);
    check("p2.count_kept", count, DEPTH);
    en        = 1'b0;
    out_ready = 1'b1;
    repeat (5) cycle("p2d");
    check("p2.drained", out_valid, 0);

    // Full FIFO popped exactly on a strobe cycle: push and pop both happen.
    clr_ovf = 1'b1;
    cycle("p3c");
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    en        = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ave8 = WIDTH'(k);
      run_to_strobe("p3");
    end
    check("p3.count_full", count, DEPTH);
    ave8 = 8'd9;
    run_to_pre_strobe("p3");
    out_ready = 1'b1;
    cycle("p3s");
    check("p3.count_stays", count, DEPTH);
    check("p3.no_ovf", overflow, 0);
    en = 1'b0;
    got.delete();
    repeat (6) begin
      if (out_valid === 1'b1) got.push_back(int'(out_data));
      cycle("p3d");
    end
    exp_order = '{2, 3, 4, 9};
    check("p3.drain_len", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("p3.drain_order", got[i], exp_order[i]);

    // Capture disabled across two strobes, then re-enabled on the grid.
    en        = 1'b0;
    out_ready = 1'b1;
    repeat (2 * PERIOD) cycle("p4");
    check("p4.count", count, 0);
    check("p4.ovf", overflow, 0);
    en   = 1'b1;
    ave8 = 8'h5C;
    run_to_strobe("p4");
    check("p4.captured", out_valid, 1);
    check("p4.data", out_data, 8'h5C);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if (i % 100 > 60) out_ready = 1'b0;
      clr_ovf   = ($urandom_range(0, 7) == 0);
      ave8      = WIDTH'($urandom_range(0, 255));
`ifdef AVE_CAPTURE_MINMAX_EN
      clr_stats = ($urandom_range(0, 15) == 0);
`endif
      cycle("rnd");
    end
    clr_ovf = 1'b0;
`ifdef AVE_CAPTURE_MINMAX_EN
    clr_stats = 1'b0;
`endif

    // Asynchronous reset with three entries queued.
    en        = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle("p5d");
    en        = 1'b1;
    out_ready = 1'b0;
    g = 0;
    while (q.size() != 3 && g < 100) begin
      ave8 = WIDTH'($urandom_range(1, 255));
      cycle("p5f");
      g++;
    end
    check("p5.count3", count, 3);
    #2;
    rs = 1'b0;
    #1;
    check("p5.async_valid", out_valid, 0);
    check("p5.async_count", count, 0);
    check("p5.async_ovf", overflow, 0);
    check("p5.async_data", out_data, 0);
`ifdef AVE_CAPTURE_MINMAX_EN
    check("p5.async_min", min8, 8'hFF);
    check("p5.async_max", max8, 8'h00);
`endif
    model_reset();
    @(negedge clk);
    rs        = 1'b1;
    out_ready = 1'b1;
    ave8      = 8'h33;
    repeat (OFFSET - 1) cycle("p5r");
    check("p5.no_early", out_valid, 0);
    cycle("p5r");
    check("p5.first", out_valid, 1);
    check("p5.first_data", out_data, 8'h33);

`ifdef AVE_CAPTURE_MINMAX_EN
    // Min/max statistics.
    if (strobe_at(e + 1)) cycle("p6");
    clr_stats = 1'b1;
    cycle("p6");
    clr_stats = 1'b0;
    check("p6.clr_min", min8, 8'hFF);
    check("p6.clr_max", max8, 8'h00);
    en = 1'b1;
    ave8 = 8'd50;  run_to_strobe("p6");
    ave8 = 8'd10;  run_to_strobe("p6");
    ave8 = 8'd200; run_to_strobe("p6");
    check("p6.min", min8, 10);
    check("p6.max", max8, 200);
    if (strobe_at(e + 1)) cycle("p6");
    clr_stats = 1'b1;
    cycle("p6");
    clr_stats = 1'b0;
    check("p6.clr2_min", min8, 8'hFF);
    check("p6.clr2_max", max8, 8'h00);
    ave8 = 8'd77;
    run_to_pre_strobe("p6");
    clr_stats = 1'b1;
    cycle("p6");
    clr_stats = 1'b0;
    check("p6.coin_min", min8, 77);
    check("p6.coin_max", max8, 77);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
